mc_control_v2: RTL and testbench
================================

Name: mc_control_v2

Overview:
Next-generation multicycle MIPS main control FSM. It adds a memory-ready handshake with a parametrised timeout, an extended instruction set (bne, jal, addi, andi, ori, slti) and an illegal-opcode/timeout trap. It sits beside the datapath and drives the same mux, enable and ALU-control signals, widened where new paths need them.

Parameters:
USE_MEM_READY, 1, 1 = memory states wait on mem_ready; 0 = memory completes in one cycle.
MEM_TIMEOUT, 15, maximum wait cycles in one memory state before trap; 0 = no timeout.
CNT_W, 32, width of the performance counters (Optional Feature only).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
Op  in  6  instruction opcode, IR[31:26]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
IorD  out  1  0 = PC addresses memory; 1 = ALUOut addresses memory
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR load enable
ALUSrcA  out  1  0 = PC; 1 = reg A
ALUSrcB  out  2  00 = B; 01 = 4; 10 = imm; 11 = imm<<2
ZeroExt  out  1  1 = imm zero-extended; 0 = imm sign-extended
ALUOp  out  3  000 = add; 001 = sub; 010 = funct; 011 = and; 100 = or; 101 = slt
PCSource  out  2  00 = ALU; 01 = ALUOut; 10 = jump target
PCSel  out  1  PC write enable, branch condition already resolved
RegWrite  out  1  register file write enable
RegDst  out  2  00 = rt; 01 = rd; 10 = r31
MemToReg  out  2  00 = ALUOut; 01 = MDR; 10 = PC
trap  out  1  sticky fault indicator
instr_count  out  CNT_W  retired instructions (Optional Feature only)
cycle_count  out  CNT_W  cycles since reset (Optional Feature only)

Behaviour:
- Reset: synchronous; on the next clk edge state = FETCH, wait counter = 0, trap = 0. The first FETCH cycle after reset issues MemRead.
- Outputs are combinational from the state. Every output defaults to 0 in every state unless listed below.
- FETCH: MemRead = 1, ALUSrcB = 01, ALUOp = 000.
  - IRWrite = 1 and PCSel = 1 only in the cycle the access completes (mem_ready = 1, or always when USE_MEM_READY = 0). The PC therefore increments exactly once per fetch.
  - On completion go to DECODE; otherwise stay in FETCH.
- DECODE: ALUSrcB = 11, ALUOp = 000. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTEXE
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL
  - 001000, 001010, 001100, 001101 -> IMMEXE
  - any other opcode -> TRAP
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 000. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead = 1, IorD = 1. Wait on mem_ready as in FETCH, then go to MEMWB.
- MEMWB: RegWrite = 1, MemToReg = 01, RegDst = 00. Go to FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Wait on mem_ready as in FETCH, then go to FETCH.
- RTEXE: ALUSrcA = 1, ALUOp = 010. Go to RTWB.
- RTWB: RegWrite = 1, RegDst = 01. Go to FETCH.
- BRANCH: ALUSrcA = 1, ALUOp = 001, PCSource = 01.
  - PCSel = Zero for beq (000100), ~Zero for bne (000101).
  - Go to FETCH.
- JUMP: PCSource = 10, PCSel = 1. Go to FETCH.
- JAL: single cycle. RegWrite = 1, RegDst = 10, MemToReg = 10 (PC already holds PC+4), PCSource = 10, PCSel = 1. Go to FETCH.
- IMMEXE: ALUSrcA = 1, ALUSrcB = 10.
  - addi: ALUOp = 000, ZeroExt = 0
  - slti: ALUOp = 101, ZeroExt = 0
  - andi: ALUOp = 011, ZeroExt = 1
  - ori: ALUOp = 100, ZeroExt = 1
  - Go to IMMWB.
- IMMWB: RegWrite = 1, RegDst = 00, MemToReg = 00. ZeroExt is held at its IMMEXE value. Go to FETCH.
- Timeout:
  - The wait counter increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - It clears on any state change.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT while mem_ready is still 0, go to TRAP.
  - mem_ready = 1 on the same cycle as the counter reaching MEM_TIMEOUT counts as completion, not a timeout.
- TRAP: trap = 1, all other outputs 0. Absorbing state; only reset leaves it.
- Reset during a memory wait: the access is abandoned and no strobe is asserted on the reset edge's next cycle except the FETCH MemRead.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined:
  - Ports instr_count and cycle_count exist, both reset to 0.
  - cycle_count increments every cycle while not in TRAP.
  - instr_count increments on each transition into FETCH from MEMWB, MEMWR, RTWB, BRANCH, JUMP, JAL or IMMWB.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: the ports and counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- lw with mem_ready low 3 cycles in FETCH and 2 in MEMRD -> IRWrite/PCSel pulse exactly once; 10 cycles FETCH-to-FETCH; MEMWB has RegWrite = 1, MemToReg = 01.
- beq with Zero = 0, then bne with Zero = 0 -> PCSel = 0 then PCSel = 1 in BRANCH; PCSource = 01 both times.
- jal (000011) -> JAL state has RegDst = 10, MemToReg = 10, PCSel = 1, PCSource = 10; next state FETCH.
- ori (001101) -> IMMEXE has ALUOp = 100, ZeroExt = 1; IMMWB has RegWrite = 1, RegDst = 00.
- Op = 111111 -> TRAP after DECODE, trap = 1 and held; reset clears it and FETCH resumes.
- MEM_TIMEOUT = 4, mem_ready stuck 0 in MEMWR -> TRAP after exactly 4 wait cycles. With MC_PERF_CNT_EN defined, instr_count is unchanged by the trapped instruction.

Source files
------------

// File: rtl/mc_control_v2_if.sv
// mc_control_v2_if: control bus between the mc_control_v2 FSM and the MIPS datapath
//   master : controller side (takes Op/Zero/mem_ready, drives mux/enable/ALU controls and trap)
//   slave  : datapath side (mirror of master)
//   MC_PERF_CNT_EN adds instr_count/cycle_count (CNT_W bits) to the bus
interface mc_control_v2_if
`ifdef MC_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [5:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ZeroExt;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       PCSel;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemToReg;
  logic       trap;
`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;
`endif
  modport master (
    input  Op, Zero, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, ALUSrcA, ALUSrcB, ZeroExt, ALUOp,
           PCSource, PCSel, RegWrite, RegDst, MemToReg, trap
`ifdef MC_PERF_CNT_EN
    , output instr_count, cycle_count
`endif
  );
  modport slave (
    output Op, Zero, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, ALUSrcA, ALUSrcB, ZeroExt, ALUOp,
           PCSource, PCSel, RegWrite, RegDst, MemToReg, trap
`ifdef MC_PERF_CNT_EN
    , input instr_count, cycle_count
`endif
  );
endinterface

// File: rtl/mc_control_v2.sv
// mc_control_v2: multicycle MIPS main control FSM with mem_ready handshake, wait timeout and trap
//   clk, reset : clock, synchronous active-high reset
//   bus        : mc_control_v2_if.master (Op/Zero/mem_ready in, datapath controls and trap out)
//   MC_PERF_CNT_EN enables instr_count/cycle_count performance counters (CNT_W bits)
module mc_control_v2 #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int MEM_TIMEOUT   = 15
`ifdef MC_PERF_CNT_EN
  , parameter int CNT_W       = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  mc_control_v2_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB,
    BRANCH, JUMP, JAL, IMMEXE, IMMWB, TRAP
  } state_t;
  localparam int WW = $clog2(MEM_TIMEOUT + 2);
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          done, tmo, in_mem, zext;
  assign done   = USE_MEM_READY ? bus.mem_ready : 1'b1;
  assign in_mem = state_q inside {FETCH, MEMRD, MEMWR};
  // timeout fires on the wait cycle that would bring the counter to MEM_TIMEOUT
  assign tmo    = MEM_TIMEOUT != 0 && !done && int'(wait_q) + 1 == MEM_TIMEOUT;
  assign wait_d = (in_mem && state_d == state_q) ? wait_q + 1'b1 : '0;
  // andi/ori have Op[2] set, addi/slti do not
  assign zext   = bus.Op[2];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.ZeroExt  = 1'b0;
    bus.ALUOp    = 3'b000;
    bus.PCSource = 2'b00;
    bus.PCSel    = 1'b0;
    bus.RegWrite = 1'b0;
    bus.RegDst   = 2'b00;
    bus.MemToReg = 2'b00;
    bus.trap     = 1'b0;
    case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = done;
        bus.PCSel   = done;
        state_d     = done ? DECODE : tmo ? TRAP : FETCH;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Op)
          6'b100011, 6'b101011:                     state_d = MEMADR;
          6'b000000:                                state_d = RTEXE;
          6'b000100, 6'b000101:                     state_d = BRANCH;
          6'b000010:                                state_d = JUMP;
          6'b000011:                                state_d = JAL;
          6'b001000, 6'b001010, 6'b001100, 6'b001101: state_d = IMMEXE;
          default:                                  state_d = TRAP;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = bus.Op == 6'b101011 ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = done ? MEMWB : tmo ? TRAP : MEMRD;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 2'b01;
        state_d      = FETCH;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        state_d      = done ? FETCH : tmo ? TRAP : MEMWR;
      end
      RTEXE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 3'b010;
        state_d     = RTWB;
      end
      RTWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b01;
        state_d      = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = 3'b001;
        bus.PCSource = 2'b01;
        bus.PCSel    = bus.Zero ^ bus.Op[0];
        state_d      = FETCH;
      end
      JUMP: begin
        bus.PCSource = 2'b10;
        bus.PCSel    = 1'b1;
        state_d      = FETCH;
      end
      JAL: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b10;
        bus.MemToReg = 2'b10;
        bus.PCSource = 2'b10;
        bus.PCSel    = 1'b1;
        state_d      = FETCH;
      end
      IMMEXE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ZeroExt = zext;
        bus.ALUOp   = bus.Op == 6'b001101 ? 3'b100 :
                      bus.Op == 6'b001100 ? 3'b011 :
                      bus.Op == 6'b001010 ? 3'b101 : 3'b000;
        state_d     = IMMWB;
      end
      IMMWB: begin
        bus.RegWrite = 1'b1;
        bus.ZeroExt  = zext;
        state_d      = FETCH;
      end
      default: bus.trap = 1'b1;
    endcase
  end
`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instr_q, cycle_q;
  logic             retire;
  assign retire = state_d == FETCH && state_q inside {MEMWB, MEMWR, RTWB, BRANCH, JUMP, JAL, IMMWB};
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      if (state_q != TRAP) cycle_q <= cycle_q + 1'b1;
      if (retire) instr_q <= instr_q + 1'b1;
    end
  end
  assign bus.instr_count = instr_q;
  assign bus.cycle_count = cycle_q;
`endif
endmodule

// File: tb/tb_mc_control_v2.sv
// tb_mc_control_v2: directed self-checking bench for mc_control_v2 (MEM_TIMEOUT = 4)
module tb_mc_control_v2;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   irw_n = 0;
  int   pcs_n = 0;
  mc_control_v2_if bus ();
  mc_control_v2 #(.USE_MEM_READY(1'b1), .MEM_TIMEOUT(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [19:0] v(input int iord, mr, mw, irw, asa, asb, ze, aop,
                                    psrc, psel, rw, rd, m2r, tr);
    return {1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(asa), 2'(asb), 1'(ze), 3'(aop),
            2'(psrc), 1'(psel), 1'(rw), 2'(rd), 2'(m2r), 1'(tr)};
  endfunction
  //                         iord mr mw irw asa asb ze aop psrc psel rw rd m2r tr
  localparam logic [19:0] F_WAIT = v(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [19:0] F_DONE = v(0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
  localparam logic [19:0] DEC    = v(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [19:0] MADR   = v(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [19:0] MRD    = v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [19:0] MWB    = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
  localparam logic [19:0] MWR    = v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [19:0] RTX    = v(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
  localparam logic [19:0] RTW    = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
  localparam logic [19:0] BR_N   = v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
  localparam logic [19:0] BR_T   = v(0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
  localparam logic [19:0] JALS   = v(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 2, 2, 0);
  localparam logic [19:0] ORIX   = v(0, 0, 0, 0, 1, 2, 1, 4, 0, 0, 0, 0, 0, 0);
  localparam logic [19:0] ORIW   = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
  localparam logic [19:0] TRP    = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  logic [19:0] obs;
  assign obs = {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.ALUSrcA, bus.ALUSrcB,
                bus.ZeroExt, bus.ALUOp, bus.PCSource, bus.PCSel, bus.RegWrite, bus.RegDst,
                bus.MemToReg, bus.trap};
  task automatic step(input string tag, input logic [19:0] exp);
    #1;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    irw_n += int'(bus.IRWrite);
    pcs_n += int'(bus.PCSel);
    @(posedge clk);
    #2;
  endtask
  task automatic chk_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.Op = 6'b100011;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    step("rst_fetch", F_WAIT);
    step("lw_fwait2", F_WAIT);
    step("lw_fwait3", F_WAIT);
    bus.mem_ready = 1'b1;
    step("lw_fdone", F_DONE);
    bus.mem_ready = 1'b0;
    step("lw_dec", DEC);
    step("lw_adr", MADR);
    step("lw_rd1", MRD);
    step("lw_rd2", MRD);
    bus.mem_ready = 1'b1;
    step("lw_rd3", MRD);
    step("lw_wb", MWB);
    chk_int("lw_irwrite_pulses", irw_n, 1);
    chk_int("lw_pcsel_pulses", pcs_n, 1);
    bus.Op = 6'b000100;
    step("beq_f", F_DONE);
    step("beq_dec", DEC);
    step("beq_br", BR_N);
    bus.Op = 6'b000101;
    step("bne_f", F_DONE);
    step("bne_dec", DEC);
    step("bne_br", BR_T);
    bus.Op = 6'b000011;
    step("jal_f", F_DONE);
    step("jal_dec", DEC);
    step("jal", JALS);
    bus.Op = 6'b001101;
    step("jal_next_fetch", F_DONE);
    step("ori_dec", DEC);
    step("ori_exe", ORIX);
    step("ori_wb", ORIW);
    bus.Op = 6'b000000;
    step("rt_f", F_DONE);
    step("rt_dec", DEC);
    step("rt_exe", RTX);
    step("rt_wb", RTW);
    bus.Op = 6'b101011;
    step("sw_f", F_DONE);
    step("sw_dec", DEC);
    step("sw_adr", MADR);
    bus.mem_ready = 1'b0;
    step("sw_wr1", MWR);
    step("sw_wr2", MWR);
    step("sw_wr3", MWR);
    bus.mem_ready = 1'b1;
    step("sw_wr4_ready_at_limit", MWR);
`ifdef MC_PERF_CNT_EN
    #1;
    chk_int("instr_count_7", int'(bus.instr_count), 7);
`endif
    bus.Op = 6'b111111;
    step("ill_f", F_DONE);
    step("ill_dec", DEC);
    step("ill_trap", TRP);
    bus.mem_ready = 1'b0;
    step("trap_held1", TRP);
    bus.Zero = 1'b1;
    step("trap_held2", TRP);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.Zero = 1'b0;
    bus.Op = 6'b101011;
`ifdef MC_PERF_CNT_EN
    #1;
    chk_int("instr_count_reset", int'(bus.instr_count), 0);
`endif
    step("post_trap_fetch", F_DONE);
    step("tmo_dec", DEC);
    step("tmo_adr", MADR);
    bus.mem_ready = 1'b0;
    step("tmo_wr1", MWR);
    step("tmo_wr2", MWR);
    step("tmo_wr3", MWR);
    step("tmo_wr4", MWR);
    step("tmo_trap", TRP);
    step("tmo_trap_held", TRP);
`ifdef MC_PERF_CNT_EN
    #1;
    chk_int("instr_count_after_tmo", int'(bus.instr_count), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
